// File: rtl/commit_unit_pkg.sv
// Shared widths, instruction-id encoding and class ranges for the commit stage.
// The id map groups branches and stores into contiguous ranges so classification is a pair of compares.
package commit_unit_pkg;

    localparam int InstrIdWidth = 6;
    localparam int RegIdxWidth  = 5;
    localparam int ROBIdxWidth  = 4;
    localparam int LSBIdxWidth  = 4;
    localparam int WordWidth    = 32;
    localparam int AddrWidth    = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [WordWidth-1:0] ZERO = '0;

    typedef logic [InstrIdWidth-1:0] instr_id_t;

    localparam instr_id_t ID_NOP   = 6'd0;
    localparam instr_id_t ID_LUI   = 6'd1;
    localparam instr_id_t ID_AUIPC = 6'd2;
    localparam instr_id_t ID_JAL   = 6'd3;
    localparam instr_id_t ID_JALR  = 6'd4;
    localparam instr_id_t ID_BEQ   = 6'd5;
    localparam instr_id_t ID_BNE   = 6'd6;
    localparam instr_id_t ID_BLT   = 6'd7;
    localparam instr_id_t ID_BGE   = 6'd8;
    localparam instr_id_t ID_BLTU  = 6'd9;
    localparam instr_id_t ID_BGEU  = 6'd10;
    localparam instr_id_t ID_LB    = 6'd11;
    localparam instr_id_t ID_LH    = 6'd12;
    localparam instr_id_t ID_LW    = 6'd13;
    localparam instr_id_t ID_LBU   = 6'd14;
    localparam instr_id_t ID_LHU   = 6'd15;
    localparam instr_id_t ID_SB    = 6'd16;
    localparam instr_id_t ID_SH    = 6'd17;
    localparam instr_id_t ID_SW    = 6'd18;
    localparam instr_id_t ID_ADDI  = 6'd19;
    localparam instr_id_t ID_ADD   = 6'd28;
    localparam instr_id_t ID_SUB   = 6'd29;
    localparam instr_id_t ID_HALT  = 6'd63;

    localparam instr_id_t ID_BRANCH_LO = ID_BEQ;
    localparam instr_id_t ID_BRANCH_HI = ID_BGEU;
    localparam instr_id_t ID_STORE_LO  = ID_SB;
    localparam instr_id_t ID_STORE_HI  = ID_SW;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

endpackage

// File: rtl/commit_classify.sv
// Pure combinational map from a decoded instruction id to its retirement class.
module commit_classify
    import commit_unit_pkg::*;
(
    input  logic [InstrIdWidth-1:0] instr_id,
    output logic                    is_store,
    output logic                    is_branch,
    output logic                    writes_rd
);

    always_comb begin
        is_store  = (instr_id >= ID_STORE_LO) && (instr_id <= ID_STORE_HI);
        is_branch = (instr_id >= ID_BRANCH_LO) && (instr_id <= ID_BRANCH_HI);
        writes_rd = !is_store && !is_branch && (instr_id != ID_NOP) && (instr_id != ID_HALT);
    end

endmodule

// File: rtl/commit_unit.sv
// Consumer of the ROB commit port: issues regfile writes, store releases and branch-recovery flushes.
// Every output is registered, so actions appear one cycle after the commit is sampled.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   commit_en_in,
    input  logic [InstrIdWidth-1:0] instr_id_in,
    input  logic [RegIdxWidth-1:0] rd_in,
    input  logic [ROBIdxWidth-1:0] rob_pos_in,
    input  logic [LSBIdxWidth-1:0] lsb_pos_in,
    input  logic [WordWidth-1:0]   res_in,
    input  logic                   jump_en_in,
    input  logic [AddrWidth-1:0]   jump_a_in,
    output logic                   reg_wr_en_out,
    output logic [RegIdxWidth-1:0] reg_wr_rd_out,
    output logic [WordWidth-1:0]   reg_wr_data_out,
    output logic [ROBIdxWidth-1:0] reg_wr_rob_pos_out,
    output logic                   lsb_commit_en_out,
    output logic [LSBIdxWidth-1:0] lsb_commit_pos_out,
    output logic                   clear_branch_out,
    output logic                   redirect_en_out,
    output logic [AddrWidth-1:0]   redirect_pc_out,
    output logic [CNT_WIDTH-1:0]   commit_cnt_out,
    output logic [CNT_WIDTH-1:0]   flush_cnt_out
);

    // fcnt counts the clear cycles still owed after the one issued with the redirect
    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

    commit_state_t state, state_next;
    logic [2:0] fcnt, fcnt_next;

    logic is_store, writes_rd, is_branch_unused;

    logic                   reg_wr_en_nx;
    logic [RegIdxWidth-1:0] reg_wr_rd_nx;
    logic [WordWidth-1:0]   reg_wr_data_nx;
    logic [ROBIdxWidth-1:0] reg_wr_rob_pos_nx;
    logic                   lsb_commit_en_nx;
    logic [LSBIdxWidth-1:0] lsb_commit_pos_nx;
    logic                   clear_branch_nx;
    logic                   redirect_en_nx;
    logic [AddrWidth-1:0]   redirect_pc_nx;
    logic [CNT_WIDTH-1:0]   commit_cnt_nx;
    logic [CNT_WIDTH-1:0]   flush_cnt_nx;

    // Branches act only through jump_en_in here, so the branch flag is left unused.
    commit_classify u_classify (
        .instr_id  (instr_id_in),
        .is_store  (is_store),
        .is_branch (is_branch_unused),
        .writes_rd (writes_rd)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else if (rdy_in) begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_comb begin
        state_next        = state;
        fcnt_next         = fcnt;
        reg_wr_en_nx      = FALSE;
        reg_wr_rd_nx      = reg_wr_rd_out;
        reg_wr_data_nx    = reg_wr_data_out;
        reg_wr_rob_pos_nx = reg_wr_rob_pos_out;
        lsb_commit_en_nx  = FALSE;
        lsb_commit_pos_nx = lsb_commit_pos_out;
        clear_branch_nx   = FALSE;
        redirect_en_nx    = FALSE;
        redirect_pc_nx    = redirect_pc_out;
        commit_cnt_nx     = commit_cnt_out;
        flush_cnt_nx      = flush_cnt_out;

        case (state)
            IDLE: begin
                if (commit_en_in) begin
                    commit_cnt_nx = commit_cnt_out + CNT_WIDTH'(1);
                    if (writes_rd && (rd_in != '0)) begin
                        reg_wr_en_nx      = TRUE;
                        reg_wr_rd_nx      = rd_in;
                        reg_wr_data_nx    = res_in;
                        reg_wr_rob_pos_nx = rob_pos_in;
                    end
                    if (is_store) begin
                        lsb_commit_en_nx  = TRUE;
                        lsb_commit_pos_nx = lsb_pos_in;
                    end
                    if (jump_en_in) begin
                        redirect_en_nx  = TRUE;
                        redirect_pc_nx  = jump_a_in;
                        clear_branch_nx = TRUE;
                        flush_cnt_nx    = flush_cnt_out + CNT_WIDTH'(1);
                        if (FlushInit != 3'd0) begin
                            state_next = FLUSH;
                            fcnt_next  = FlushInit;
                        end
                    end
                end
            end
            FLUSH: begin
                clear_branch_nx = TRUE;
                fcnt_next       = fcnt - 3'd1;
                if (fcnt <= 3'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            reg_wr_en_out      <= FALSE;
            reg_wr_rd_out      <= '0;
            reg_wr_data_out    <= ZERO;
            reg_wr_rob_pos_out <= '0;
            lsb_commit_en_out  <= FALSE;
            lsb_commit_pos_out <= '0;
            clear_branch_out   <= FALSE;
            redirect_en_out    <= FALSE;
            redirect_pc_out    <= '0;
            commit_cnt_out     <= '0;
            flush_cnt_out      <= '0;
        end else if (rdy_in) begin
            reg_wr_en_out      <= reg_wr_en_nx;
            reg_wr_rd_out      <= reg_wr_rd_nx;
            reg_wr_data_out    <= reg_wr_data_nx;
            reg_wr_rob_pos_out <= reg_wr_rob_pos_nx;
            lsb_commit_en_out  <= lsb_commit_en_nx;
            lsb_commit_pos_out <= lsb_commit_pos_nx;
            clear_branch_out   <= clear_branch_nx;
            redirect_en_out    <= redirect_en_nx;
            redirect_pc_out    <= redirect_pc_nx;
            commit_cnt_out     <= commit_cnt_nx;
            flush_cnt_out      <= flush_cnt_nx;
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a FLUSH_CYCLES=3 instance for the main sequence and a
// narrow-counter FLUSH_CYCLES=1 instance for counter wrap and the zero-length flush.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic clk;
    logic rstN;
    logic rdy;
    logic commitEn;
    logic commitEnW;
    logic [InstrIdWidth-1:0] instrId;
    logic [RegIdxWidth-1:0]  rd;
    logic [ROBIdxWidth-1:0]  robPos;
    logic [LSBIdxWidth-1:0]  lsbPos;
    logic [WordWidth-1:0]    res;
    logic                    jumpEn;
    logic [AddrWidth-1:0]    jumpA;

    logic                   regWrEn, regWrEnW;
    logic [RegIdxWidth-1:0] regWrRd, regWrRdW;
    logic [WordWidth-1:0]   regWrData, regWrDataW;
    logic [ROBIdxWidth-1:0] regWrRob, regWrRobW;
    logic                   lsbEn, lsbEnW;
    logic [LSBIdxWidth-1:0] lsbPosOut, lsbPosOutW;
    logic                   clearBr, clearBrW;
    logic                   redirEn, redirEnW;
    logic [AddrWidth-1:0]   redirPc, redirPcW;
    logic [31:0]            commitCnt, flushCnt;
    logic [2:0]             commitCntW, flushCntW;

    int testsRun    = 0;
    int testsFailed = 0;

    commit_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut (
        .clk_in(clk), .rst_n_in(rstN), .rdy_in(rdy), .commit_en_in(commitEn),
        .instr_id_in(instrId), .rd_in(rd), .rob_pos_in(robPos), .lsb_pos_in(lsbPos),
        .res_in(res), .jump_en_in(jumpEn), .jump_a_in(jumpA),
        .reg_wr_en_out(regWrEn), .reg_wr_rd_out(regWrRd), .reg_wr_data_out(regWrData),
        .reg_wr_rob_pos_out(regWrRob), .lsb_commit_en_out(lsbEn), .lsb_commit_pos_out(lsbPosOut),
        .clear_branch_out(clearBr), .redirect_en_out(redirEn), .redirect_pc_out(redirPc),
        .commit_cnt_out(commitCnt), .flush_cnt_out(flushCnt)
    );

    commit_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(3)) dutW (
        .clk_in(clk), .rst_n_in(rstN), .rdy_in(rdy), .commit_en_in(commitEnW),
        .instr_id_in(instrId), .rd_in(rd), .rob_pos_in(robPos), .lsb_pos_in(lsbPos),
        .res_in(res), .jump_en_in(jumpEn), .jump_a_in(jumpA),
        .reg_wr_en_out(regWrEnW), .reg_wr_rd_out(regWrRdW), .reg_wr_data_out(regWrDataW),
        .reg_wr_rob_pos_out(regWrRobW), .lsb_commit_en_out(lsbEnW), .lsb_commit_pos_out(lsbPosOutW),
        .clear_branch_out(clearBrW), .redirect_en_out(redirEnW), .redirect_pc_out(redirPcW),
        .commit_cnt_out(commitCntW), .flush_cnt_out(flushCntW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [InstrIdWidth-1:0] id,
                                 input logic [RegIdxWidth-1:0] r, input logic [ROBIdxWidth-1:0] rob,
                                 input logic [LSBIdxWidth-1:0] lsb, input logic [WordWidth-1:0] val,
                                 input logic jen, input logic [AddrWidth-1:0] ja);
        commitEn = en;
        instrId  = id;
        rd       = r;
        robPos   = rob;
        lsbPos   = lsb;
        res      = val;
        jumpEn   = jen;
        jumpA    = ja;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN = 1'b0;
        rdy  = 1'b1;
        commitEnW = 1'b0;
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_reg_wr_en", regWrEn, 0);
        checkOutput("rst_reg_wr_data", regWrData, 0);
        checkOutput("rst_lsb_en", lsbEn, 0);
        checkOutput("rst_clear", clearBr, 0);
        checkOutput("rst_redirect_en", redirEn, 0);
        checkOutput("rst_redirect_pc", redirPc, 0);
        checkOutput("rst_commit_cnt", commitCnt, 0);
        checkOutput("rst_flush_cnt", flushCnt, 0);

        // Plain ALU commit, then the rd=0 variant that must not write
        rstN = 1'b1;
        applyStimulus(1, ID_ADD, 5, 3, 0, 32'h11, 0, 0);
        tick();
        checkOutput("add_wr_en", regWrEn, 1);
        checkOutput("add_wr_rd", regWrRd, 5);
        checkOutput("add_wr_data", regWrData, 32'h11);
        checkOutput("add_wr_tag", regWrRob, 3);
        checkOutput("add_cnt", commitCnt, 1);
        checkOutput("add_lsb_en", lsbEn, 0);
        applyStimulus(1, ID_ADD, 0, 4, 0, 32'h22, 0, 0);
        tick();
        checkOutput("rd0_wr_en", regWrEn, 0);
        checkOutput("rd0_data_hold", regWrData, 32'h11);
        checkOutput("rd0_cnt", commitCnt, 2);

        // Store release, then strobe drop
        applyStimulus(1, ID_SW, 7, 2, 6, 32'h99, 0, 0);
        tick();
        checkOutput("sw_lsb_en", lsbEn, 1);
        checkOutput("sw_lsb_pos", lsbPosOut, 6);
        checkOutput("sw_wr_en", regWrEn, 0);
        checkOutput("sw_cnt", commitCnt, 3);
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("sw_lsb_drop", lsbEn, 0);
        checkOutput("idle_cnt", commitCnt, 3);

        // Load writes rd but releases nothing to the LSB
        applyStimulus(1, ID_LW, 8, 5, 2, 32'h55, 0, 0);
        tick();
        checkOutput("lw_wr_en", regWrEn, 1);
        checkOutput("lw_wr_rd", regWrRd, 8);
        checkOutput("lw_lsb_en", lsbEn, 0);
        checkOutput("lw_cnt", commitCnt, 4);

        // Mispredicted BEQ: three clear cycles, commits ignored during the flush
        applyStimulus(1, ID_BEQ, 9, 6, 0, 32'h0, 1, 32'h1000);
        tick();
        checkOutput("beq_redirect_en", redirEn, 1);
        checkOutput("beq_redirect_pc", redirPc, 32'h1000);
        checkOutput("beq_clear1", clearBr, 1);
        checkOutput("beq_wr_en", regWrEn, 0);
        checkOutput("beq_flush_cnt", flushCnt, 1);
        checkOutput("beq_cnt", commitCnt, 5);
        applyStimulus(1, ID_ADD, 10, 6, 0, 32'hAA, 0, 0);
        tick();
        checkOutput("beq_clear2", clearBr, 1);
        checkOutput("beq_redirect_drop", redirEn, 0);
        checkOutput("flush_ign_wr", regWrEn, 0);
        checkOutput("flush_ign_cnt", commitCnt, 5);
        tick();
        checkOutput("beq_clear3", clearBr, 1);
        checkOutput("flush_ign_cnt2", commitCnt, 5);
        tick();
        checkOutput("beq_clear_end", clearBr, 0);
        checkOutput("post_flush_wr", regWrEn, 1);
        checkOutput("post_flush_data", regWrData, 32'hAA);
        checkOutput("post_flush_cnt", commitCnt, 6);
        checkOutput("pc_hold", redirPc, 32'h1000);

        // JAL: link write and redirect in the same cycle
        applyStimulus(1, ID_JAL, 1, 7, 0, 32'h204, 1, 32'h300);
        tick();
        checkOutput("jal_wr_en", regWrEn, 1);
        checkOutput("jal_wr_rd", regWrRd, 1);
        checkOutput("jal_wr_data", regWrData, 32'h204);
        checkOutput("jal_redirect_en", redirEn, 1);
        checkOutput("jal_redirect_pc", redirPc, 32'h300);
        checkOutput("jal_clear1", clearBr, 1);
        checkOutput("jal_flush_cnt", flushCnt, 2);
        checkOutput("jal_cnt", commitCnt, 7);
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("jal_clear2", clearBr, 1);
        checkOutput("jal_wr_drop", regWrEn, 0);
        tick();
        checkOutput("jal_clear3", clearBr, 1);
        tick();
        checkOutput("jal_clear_end", clearBr, 0);

        // rdy low mid-flush freezes pulses and the flush countdown
        applyStimulus(1, ID_BNE, 0, 8, 0, 0, 1, 32'h400);
        tick();
        checkOutput("bne_clear1", clearBr, 1);
        checkOutput("bne_flush_cnt", flushCnt, 3);
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_clear", clearBr, 1);
            checkOutput("stall_redirect_hold", redirEn, 1);
        end
        checkOutput("stall_cnt", commitCnt, 8);
        rdy = 1'b1;
        tick();
        checkOutput("resume_clear2", clearBr, 1);
        checkOutput("resume_redirect_drop", redirEn, 0);
        tick();
        checkOutput("resume_clear3", clearBr, 1);
        tick();
        checkOutput("resume_clear_end", clearBr, 0);

        // Reset during a flush abandons it
        applyStimulus(1, ID_BLT, 0, 9, 0, 0, 1, 32'h500);
        tick();
        checkOutput("blt_clear1", clearBr, 1);
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        rstN = 1'b0;
        tick();
        checkOutput("midrst_clear", clearBr, 0);
        checkOutput("midrst_redirect_en", redirEn, 0);
        checkOutput("midrst_pc", redirPc, 0);
        checkOutput("midrst_cnt", commitCnt, 0);
        checkOutput("midrst_flush_cnt", flushCnt, 0);
        rstN = 1'b1;
        applyStimulus(1, ID_ADD, 2, 1, 0, 32'h77, 0, 0);
        tick();
        checkOutput("midrst_idle_wr", regWrEn, 1);
        checkOutput("midrst_idle_clear", clearBr, 0);
        checkOutput("midrst_idle_cnt", commitCnt, 1);

        // Eight back-to-back commits; the 3-bit counter wraps on the eighth
        rstN = 1'b0;
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, ID_ADD, 5'(i + 1), 4'(i), 0, 32'h100 + 32'(i), 0, 0);
            commitEnW = 1'b1;
            tick();
            checkOutput("b2b_wr_en", regWrEn, 1);
            checkOutput("b2b_wr_data", regWrData, 32'h100 + 32'(i));
            checkOutput("b2b_cnt", commitCnt, i + 1);
            checkOutput("wrap_cnt", commitCntW, (i + 1) % 8);
        end
        checkOutput("b2b_final_cnt", commitCnt, 8);
        checkOutput("wrap_final_cnt", commitCntW, 0);

        // FLUSH_CYCLES=1: a commit right after the redirect is accepted
        applyStimulus(1, ID_BGE, 0, 2, 0, 0, 1, 32'h600);
        tick();
        checkOutput("f1_clear", clearBrW, 1);
        checkOutput("f1_redirect_pc", redirPcW, 32'h600);
        checkOutput("f1_flush_cnt", flushCntW, 1);
        checkOutput("f1_cnt", commitCntW, 1);
        applyStimulus(1, ID_ADD, 3, 3, 0, 32'h33, 0, 0);
        tick();
        checkOutput("f1_clear_end", clearBrW, 0);
        checkOutput("f1_wr_en", regWrEnW, 1);
        checkOutput("f1_wr_data", regWrDataW, 32'h33);
        checkOutput("f1_cnt2", commitCntW, 2);
        checkOutput("f3_still_clear", clearBr, 1);
        checkOutput("f3_ign_wr", regWrEn, 0);
        commitEnW = 1'b0;
        applyStimulus(0, ID_NOP, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
